// File: rtl/stream_mux_rr_if.sv
// -----------------------------------------------------------------------------
// stream_mux_rr_if
// Bundle of the producer-side and consumer-side stream signals of stream_mux_rr.
//
// Parameters
//   N_CH   number of input channels (2..16)
//   WIDTH  data width per channel (1..64)
//   SEL_W  derived select / channel-tag width, $clog2(N_CH)
//
// Signals
//   mode       0 = external select, 1 = round-robin arbitration
//   sel        channel index used in external-select mode
//   in_data    channel i occupies bits [i*WIDTH +: WIDTH]
//   in_valid   per-channel valid
//   in_ready   per-channel ready, at most one bit high
//   out_data   registered output data
//   out_ch     channel that supplied out_data
//   out_valid  registered output valid
//   out_ready  consumer ready
//
// Modports
//   slave   the multiplexer itself
//   master  the environment: producers, consumer and mode/select control
// -----------------------------------------------------------------------------
interface stream_mux_rr_if #(
  parameter int N_CH  = 4,
  parameter int WIDTH = 8
);
  localparam int SEL_W = $clog2(N_CH);

  logic                    mode;
  logic [SEL_W-1:0]        sel;
  logic [N_CH*WIDTH-1:0]   in_data;
  logic [N_CH-1:0]         in_valid;
  logic [N_CH-1:0]         in_ready;
  logic [WIDTH-1:0]        out_data;
  logic [SEL_W-1:0]        out_ch;
  logic                    out_valid;
  logic                    out_ready;

  modport slave (
    input  mode, sel, in_data, in_valid, out_ready,
    output in_ready, out_data, out_ch, out_valid
  );

  modport master (
    output mode, sel, in_data, in_valid, out_ready,
    input  in_ready, out_data, out_ch, out_valid
  );
endinterface

// File: rtl/stream_mux_rr.sv
// -----------------------------------------------------------------------------
// stream_mux_rr
// N-channel valid/ready stream multiplexer with a one-entry registered output.
// The channel is chosen either by an external select or by a fair round-robin
// arbiter whose pointer survives mode switches.
//
// Parameters
//   N_CH   number of input channels (2..16)
//   WIDTH  data width per channel (1..64)
//
// Ports
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset; clears the output register and the
//          round-robin pointer and forces in_ready low
//   bus    stream_mux_rr_if.slave: mode, sel, in_data, in_valid, out_ready in;
//          in_ready, out_data, out_ch, out_valid out
// -----------------------------------------------------------------------------
module stream_mux_rr #(
  parameter int N_CH  = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  stream_mux_rr_if.slave   bus
);
  localparam int SEL_W = $clog2(N_CH);

  typedef enum logic {
    MODE_SEL = 1'b0,
    MODE_RR  = 1'b1
  } mode_e;

  typedef logic [SEL_W-1:0] ch_t;

  // Output register and arbitration pointer
  logic [WIDTH-1:0] data_q;
  ch_t              ch_q;
  logic             valid_q;
  ch_t              ptr_q;

  // Grant decision
  mode_e            mode;
  logic             load_en;
  logic             grant_valid;
  ch_t              grant;
  logic [WIDTH-1:0] grant_data;
  ch_t              ptr_next;
  logic [N_CH-1:0]  ready_c;
  int               idx;

  assign mode    = mode_e'(bus.mode);

  // The register can take a beat when empty or when it drains on this edge.
  assign load_en = !valid_q || bus.out_ready;

  always_comb begin
    // NOTE: every variable written here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    grant_valid = 1'b0;
    grant       = '0;
    idx         = 0;
    if (mode == MODE_SEL) begin
      // A select value >= N_CH matches no channel and simply grants nothing.
      for (int i = 0; i < N_CH; i++) begin
        if (bus.sel == ch_t'(i) && bus.in_valid[i]) begin
          grant_valid = 1'b1;
          grant       = ch_t'(i);
        end
      end
    end else begin
      // Walk the search order backwards so the last hit written is the
      // channel closest to ptr (ptr, ptr+1, ..., wrapping mod N_CH).
      for (int k = N_CH - 1; k >= 0; k--) begin
        idx = int'(ptr_q) + k;
        if (idx >= N_CH) idx = idx - N_CH;
        for (int i = 0; i < N_CH; i++) begin
          if (idx == i && bus.in_valid[i]) begin
            grant_valid = 1'b1;
            grant       = ch_t'(i);
          end
        end
      end
    end
  end

  // Data of the granted channel; constant-index slices keep the mux explicit.
  always_comb begin
    grant_data = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (grant == ch_t'(i)) grant_data = bus.in_data[i*WIDTH +: WIDTH];
    end
  end

  // Pointer moves past the granted channel; wraps at N_CH, not at 2**SEL_W.
  assign ptr_next = (grant == ch_t'(N_CH - 1)) ? '0 : grant + 1'b1;

  // in_ready is forced low while reset is asserted.
  always_comb begin
    ready_c = '0;
    for (int i = 0; i < N_CH; i++) begin
      ready_c[i] = rst_n && load_en && grant_valid && (grant == ch_t'(i));
    end
  end

  assign bus.in_ready  = ready_c;
  assign bus.out_data  = data_q;
  assign bus.out_ch    = ch_q;
  assign bus.out_valid = valid_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the data register is reset too because its value is visible on
      // out_data during reset; a beat held at reset time is discarded.
      data_q  <= '0;
      ch_q    <= '0;
      valid_q <= 1'b0;
      ptr_q   <= '0;
    end else if (load_en && grant_valid) begin
      data_q  <= grant_data;
      ch_q    <= grant;
      valid_q <= 1'b1;
      if (mode == MODE_RR) ptr_q <= ptr_next;
    end else if (bus.out_ready) begin
      valid_q <= 1'b0;
    end
  end
endmodule

// File: tb/tb_stream_mux_rr.sv
// -----------------------------------------------------------------------------
// tb_stream_mux_rr
// Drives a 4-channel and a 3-channel stream_mux_rr side by side and compares
// them cycle by cycle with a behavioural model of the multiplexer, followed by
// a randomized phase with back-pressure and mode/select changes.
// -----------------------------------------------------------------------------
module tb_stream_mux_rr;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  stream_mux_rr_if #(.N_CH(4), .WIDTH(W)) ia ();
  stream_mux_rr_if #(.N_CH(3), .WIDTH(W)) ib ();

  stream_mux_rr #(.N_CH(4), .WIDTH(W)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ia));
  stream_mux_rr #(.N_CH(3), .WIDTH(W)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ib));

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Stimulus per DUT (index 0 = 4 channels, index 1 = 3 channels)
  bit           t_mode [2];
  int           t_sel  [2];
  logic [15:0]  t_valid[2];
  logic [W-1:0] t_data [2][16];
  bit           t_ordy [2];

  // Reference model state: round-robin pointer and output register contents
  int           m_ptr[2];
  bit           m_ov [2];
  logic [W-1:0] m_od [2];
  int           m_oc [2];
  int           acc  [2];   // channel accepted on the last edge, -1 if none
  logic [15:0]  pend [2];   // channels holding an unaccepted beat

  function automatic int nch(input int d);
    return (d == 0) ? 4 : 3;
  endfunction

  function automatic logic [63:0] act(input int d, input int f);
    if (d == 0) begin
      case (f)
        0:       return 64'(ia.in_ready);
        1:       return 64'(ia.out_valid);
        2:       return 64'(ia.out_data);
        default: return 64'(ia.out_ch);
      endcase
    end else begin
      case (f)
        0:       return 64'(ib.in_ready);
        1:       return 64'(ib.out_valid);
        2:       return 64'(ib.out_data);
        default: return 64'(ib.out_ch);
      endcase
    end
  endfunction

  // Which channel the rules pick this cycle, ignoring back-pressure.
  function automatic void find_grant(input int d, output bit gv, output int g);
    int n = nch(d);
    gv = 1'b0;
    g  = 0;
    if (!t_mode[d]) begin
      if (t_sel[d] < n && t_valid[d][t_sel[d]]) begin
        gv = 1'b1;
        g  = t_sel[d];
      end
    end else begin
      for (int k = 0; k < n; k++) begin
        int c;
        c = (m_ptr[d] + k) % n;
        if (!gv && t_valid[d][c]) begin
          gv = 1'b1;
          g  = c;
        end
      end
    end
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_ptr[d] = 0;
      m_ov[d]  = 1'b0;
      m_od[d]  = '0;
      m_oc[d]  = 0;
      acc[d]   = -1;
    end
  endtask

  task automatic apply();
    ia.mode      = t_mode[0];
    ia.sel       = 2'(t_sel[0]);
    ia.in_valid  = t_valid[0][3:0];
    ia.out_ready = t_ordy[0];
    for (int i = 0; i < 4; i++) ia.in_data[i*W +: W] = t_data[0][i];
    ib.mode      = t_mode[1];
    ib.sel       = 2'(t_sel[1]);
    ib.in_valid  = t_valid[1][2:0];
    ib.out_ready = t_ordy[1];
    for (int i = 0; i < 3; i++) ib.in_data[i*W +: W] = t_data[1][i];
  endtask

  task automatic set_in(input int d, input bit m, input int s, input logic [15:0] v, input bit r);
    t_mode[d]  = m;
    t_sel[d]   = s;
    t_valid[d] = v;
    t_ordy[d]  = r;
  endtask

  task automatic check_outs(input string tag);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("%s_valid%0d", tag, d), act(d, 1), 64'(m_ov[d]));
      check($sformatf("%s_data%0d", tag, d),  act(d, 2), 64'(m_od[d]));
      check($sformatf("%s_ch%0d", tag, d),    act(d, 3), 64'(m_oc[d]));
    end
  endtask

  // One clock cycle: called at a falling edge with t_* already set.
  task automatic tick();
    bit          gv[2];
    int          g [2];
    bit          ld[2];
    logic [15:0] er;
    apply();
    #1;
    for (int d = 0; d < 2; d++) begin
      find_grant(d, gv[d], g[d]);
      ld[d] = !m_ov[d] || t_ordy[d];
      er    = (rst_n && ld[d] && gv[d]) ? (16'(1) << g[d]) : 16'(0);
      check($sformatf("ready%0d", d), act(d, 0), 64'(er));
    end
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      acc[d] = -1;
      if (ld[d] && gv[d]) begin
        m_ov[d] = 1'b1;
        m_od[d] = t_data[d][g[d]];
        m_oc[d] = g[d];
        acc[d]  = g[d];
        if (t_mode[d]) m_ptr[d] = (g[d] + 1) % nch(d);
      end else if (t_ordy[d]) begin
        m_ov[d] = 1'b0;
      end
    end
    @(negedge clk);
    check_outs("cyc");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    for (int d = 0; d < 2; d++) begin
      set_in(d, 1'b0, 0, 16'h0, 1'b0);
      for (int i = 0; i < 16; i++) t_data[d][i] = '0;
      pend[d] = '0;
    end
    model_reset();
    apply();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    check("rst0_ready_a", act(0, 0), 64'(0));
    check("rst0_ready_b", act(1, 0), 64'(0));
    check_outs("rst0");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Mode 0, full throughput: sel 0..3 on successive cycles, no bubbles.
    t_data[0][0] = 8'h11; t_data[0][1] = 8'h22; t_data[0][2] = 8'h33; t_data[0][3] = 8'h44;
    for (int s = 0; s < 4; s++) begin
      set_in(0, 1'b0, s, 16'hF, 1'b1);
      tick();
      check("m0_valid", act(0, 1), 64'(1));
      check("m0_ch",    act(0, 3), 64'(s));
      check("m0_data",  act(0, 2), 64'((s + 1) * 8'h11));
    end
    set_in(0, 1'b0, 0, 16'h0, 1'b1);
    tick();
    check("m0_drain_valid", act(0, 1), 64'(0));
    check("m0_drain_data_hold", act(0, 2), 64'(8'h44));

    // Round-robin fairness: all valid, then only channels 1 and 3.
    for (int k = 0; k < 8; k++) begin
      set_in(0, 1'b1, 0, 16'hF, 1'b1);
      tick();
      check("rr_all_ch", act(0, 3), 64'(k % 4));
    end
    for (int k = 0; k < 4; k++) begin
      set_in(0, 1'b1, 0, 16'hA, 1'b1);
      tick();
      check("rr_odd_ch", act(0, 3), 64'((k % 2 == 0) ? 1 : 3));
    end

    // Back-pressure: stored beat from channel 3 holds for 3 cycles.
    for (int k = 0; k < 3; k++) begin
      set_in(0, 1'b1, 0, 16'hF, 1'b0);
      tick();
      check("bp_ready", act(0, 0), 64'(0));
      check("bp_ch",    act(0, 3), 64'(3));
      check("bp_data",  act(0, 2), 64'(8'h44));
    end
    set_in(0, 1'b1, 0, 16'hF, 1'b1);
    tick();
    check("bp_release_valid", act(0, 1), 64'(1));
    check("bp_release_ch",    act(0, 3), 64'(0));
    set_in(0, 1'b1, 0, 16'h0, 1'b1);
    tick();

    // Mode switch mid-stream: bring ptr to 2, two external-select beats,
    // then round-robin resumes from channel 2.
    set_in(0, 1'b1, 0, 16'hF, 1'b1);
    tick();
    check("ms_pre_ch", act(0, 3), 64'(1));
    for (int k = 0; k < 2; k++) begin
      set_in(0, 1'b0, 0, 16'hF, 1'b1);
      tick();
      check("ms_sel_ch", act(0, 3), 64'(0));
    end
    for (int k = 0; k < 3; k++) begin
      set_in(0, 1'b1, 0, 16'hF, 1'b1);
      tick();
      check("ms_rr_ch", act(0, 3), 64'((k + 2) % 4));
    end
    set_in(0, 1'b1, 0, 16'h0, 1'b1);
    tick();

    // Wrap with 3 channels, then an out-of-range select.
    t_data[1][0] = 8'h0A; t_data[1][1] = 8'h0B; t_data[1][2] = 8'h0C;
    for (int k = 0; k < 4; k++) begin
      set_in(1, 1'b1, 0, 16'h7, 1'b1);
      tick();
      check("wrap3_ch", act(1, 3), 64'(k % 3));
    end
    set_in(1, 1'b0, 3, 16'h7, 1'b1);
    tick();
    check("sel3_ready", act(1, 0), 64'(0));
    check("sel3_valid", act(1, 1), 64'(0));

    // Asynchronous reset with a beat (0xA5) held under back-pressure.
    t_data[0][0] = 8'hA5;
    set_in(0, 1'b0, 0, 16'h1, 1'b0);
    set_in(1, 1'b0, 0, 16'h0, 1'b1);
    tick();
    check("pre_rst_valid", act(0, 1), 64'(1));
    check("pre_rst_data",  act(0, 2), 64'(8'hA5));
    #2 rst_n = 1'b0;
    #1;
    check("rst_valid", act(0, 1), 64'(0));
    check("rst_data",  act(0, 2), 64'(0));
    check("rst_ch",    act(0, 3), 64'(0));
    check("rst_ready", act(0, 0), 64'(0));
    model_reset();
    @(negedge clk);
    t_valid[0] = 16'h0;
    apply();
    rst_n = 1'b1;
    tick();
    check("post_rst_valid", act(0, 1), 64'(0));

    // Randomized traffic on both instances; pending beats keep valid/data.
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int d = 0; d < 2; d++) begin
        if ($urandom_range(0, 9) == 0) t_mode[d] = 1'($urandom_range(0, 1));
        t_sel[d]  = int'($urandom_range(0, 3));
        t_ordy[d] = ($urandom_range(0, 3) != 0);
        for (int i = 0; i < nch(d); i++) begin
          if (!pend[d][i]) begin
            t_valid[d][i] = 1'($urandom_range(0, 1));
            t_data[d][i]  = W'($urandom);
          end
        end
      end
      tick();
      for (int d = 0; d < 2; d++) begin
        for (int i = 0; i < nch(d); i++) pend[d][i] = t_valid[d][i] && (acc[d] != i);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
